// File: rtl/nios2_pulse_out32_pkg.sv
// Shared constants, FSM state type and pulse-length helper for the
// nios2_pulse_out32 Avalon-MM timed pulse output port.
package nios2_pulse_out32_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_PULSE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] WIDTH_RST = 16'd1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // A zero width still produces a one-cycle pulse.
  function automatic logic [COUNT_W-1:0] pulse_len(input logic [COUNT_W-1:0] width);
    return (width == '0) ? COUNT_W'(1) : width;
  endfunction

endpackage

// File: rtl/nios2_pulse_timer.sv
// Pulse duration timer: IDLE/ACTIVE FSM with a down-counter that holds the
// remaining active cycles. A start while active restarts from the new width.
module nios2_pulse_timer
  import nios2_pulse_out32_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] width,
  output logic               active,
  output logic [COUNT_W-1:0] count
);

  state_t             r_state;
  state_t             w_state_next;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    if (start) begin
      w_state_next = ST_ACTIVE;
      w_count_next = pulse_len(width);
    end else if (r_state == ST_ACTIVE) begin
      if (r_count == COUNT_W'(1)) begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end else begin
        w_count_next = r_count - COUNT_W'(1);
      end
    end
  end

  assign active = (r_state == ST_ACTIVE);
  assign count  = r_count;

endmodule

// File: rtl/nios2_pulse_out32.sv
// Avalon-MM 32-bit output port with timed pulse overlay.
// Define NIOS2_PULSE_OUT_READBACK_EN to enable the registered readdata path.
module nios2_pulse_out32
  import nios2_pulse_out32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port
);

  logic [31:0]        r_data;
  logic [COUNT_W-1:0] r_width;
  logic [31:0]        r_mask;
  logic               w_wr;
  logic               w_start;
  logic               w_active;
  logic [COUNT_W-1:0] w_count;

  assign w_wr    = chipselect & ~write_n;
  assign w_start = w_wr && (address == ADDR_PULSE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_width <= WIDTH_RST;
      r_mask  <= '0;
    end else begin
      if (w_wr && (address == ADDR_DATA))  r_data  <= writedata;
      if (w_wr && (address == ADDR_WIDTH)) r_width <= writedata[COUNT_W-1:0];
      if (w_start)                         r_mask  <= writedata;
    end
  end

  nios2_pulse_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_start),
    .width   (r_width),
    .active  (w_active),
    .count   (w_count)
  );

  assign out_port = r_data | (r_mask & {32{w_active}});

`ifdef NIOS2_PULSE_OUT_READBACK_EN
  logic [31:0] r_readdata;

  // Sampled from pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      unique case (address)
        ADDR_DATA:   r_readdata <= r_data;
        ADDR_WIDTH:  r_readdata <= {16'b0, r_width};
        ADDR_PULSE:  r_readdata <= '0;
        ADDR_STATUS: r_readdata <= {w_count, 15'b0, w_active};
        default:     r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
`else
  // Count is only observable through STATUS readback.
  logic w_unused_count;
  assign w_unused_count = ^w_count;
  assign readdata       = '0;
`endif

endmodule

// File: tb/tb_nios2_pulse_out32.sv
// Self-checking bench for nios2_pulse_out32: directed scenarios plus random
// register traffic compared against a remaining-cycles behavioural model.
module tb_nios2_pulse_out32;

`ifdef NIOS2_PULSE_OUT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;

  int total = 0;
  int bad   = 0;

  // Behavioural model: register contents plus cycles of pulse remaining.
  logic [31:0] m_data;
  logic [15:0] m_width;
  logic [31:0] m_mask;
  int          m_rem;

  nios2_pulse_out32 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_out();
    return m_data | ((m_rem > 0) ? m_mask : 32'h0);
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_width = 16'd1;
    m_mask  = '0;
    m_rem   = 0;
  endtask

  // One bus cycle: drive, clock, advance the model, check outputs #1 later.
  task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    case (a)
      2'd0:    exp_rd = m_data;
      2'd1:    exp_rd = {16'b0, m_width};
      2'd2:    exp_rd = 32'h0;
      default: exp_rd = {16'(m_rem), 15'b0, (m_rem > 0)};
    endcase
    if (!RB) exp_rd = 32'h0;
    if (m_rem > 0) m_rem--;
    if (cs && !wn) begin
      case (a)
        2'd0: m_data  = wd;
        2'd1: m_width = wd[15:0];
        2'd2: begin
          m_mask = wd;
          m_rem  = (m_width == 16'd0) ? 1 : int'(m_width);
        end
        default: ;
      endcase
    end
    #1;
    check("out_port", out_port, model_out());
    check("readdata", readdata, exp_rd);
    $display("step cs=%0b wn=%0b a=%0d wd=%08h out=%08h rd=%08h", cs, wn, a, wd, out_port, readdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [1:0] a);
    step(1'b0, 1'b1, a, 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // Reset state
    check("rst_out", out_port, 32'h0);
    idle(2'd3);
    check("rst_status", readdata, 32'h0);
    idle(2'd1);
    check("rst_width", readdata, RB ? 32'h1 : 32'h0);

    // DATA write and readback
    wr(2'd0, 32'h0000_00A5);
    check("data_out", out_port, 32'h0000_00A5);
    idle(2'd0);
    check("data_rd", readdata, RB ? 32'h0000_00A5 : 32'h0);

    // Writes with chipselect low are ignored
    step(1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF);
    check("cs_low", out_port, 32'h0000_00A5);
    wr(2'd0, 32'h0);

    // WIDTH=3 pulse of 0x100
    wr(2'd1, 32'hABCD_0003);
    wr(2'd2, 32'h0000_0100);
    check("w3_c0", out_port, 32'h100);
    for (int i = 1; i < 3; i++) begin
      idle(2'd3);
      check("w3_on", out_port, 32'h100);
    end
    idle(2'd3);
    check("w3_off", out_port, 32'h0);

    // WIDTH=0 behaves as one cycle
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h1);
    check("w0_on", out_port, 32'h1);
    idle(2'd3);
    check("w0_off", out_port, 32'h0);

    // Restart while active
    wr(2'd1, 32'd10);
    wr(2'd2, 32'h1);
    check("rs_a0", out_port, 32'h1);
    for (int i = 1; i < 4; i++) begin
      idle(2'd3);
      check("rs_a", out_port, 32'h1);
    end
    wr(2'd2, 32'h2);
    check("rs_b0", out_port, 32'h2);
    for (int i = 1; i < 10; i++) begin
      idle(2'd3);
      check("rs_b", out_port, 32'h2);
    end
    idle(2'd3);
    check("rs_off", out_port, 32'h0);

    // Zero-mask pulse: active but invisible, DATA still live
    wr(2'd1, 32'd4);
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h0000_0055);
    check("zm_data", out_port, 32'h55);
    repeat (4) idle(2'd3);
    wr(2'd0, 32'h0);

    // Reset mid-pulse
    wr(2'd1, 32'd100);
    wr(2'd2, 32'hF0F0_0001);
    repeat (5) idle(2'd3);
    check("mid_on", out_port, 32'hF0F0_0001);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out", out_port, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    idle(2'd3);
    check("mid_status", readdata, 32'h0);
    check("mid_after", out_port, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd1) wd[15:0] = 16'($urandom_range(0, 12));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), a, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
